// File: rtl/board_pkg.sv
// Shared board geometry, border masks, scan FSM states and the parent-select helper.
// Latency: none (declarations and a purely combinational function).
// Backpressure: none.
package board_pkg;

    localparam int BOARD_W = 32;
    localparam int ROWS    = 8;
    localparam int COLS    = 4;

    // Squares that a down-right shift can never legally reach (top row, column 0 of odd rows).
    localparam logic [BOARD_W-1:0] SDR_BORDER_MASK = 32'h1010_101F;
    // Squares that an up-left shift can never legally reach (bottom row, column 3 of even rows).
    localparam logic [BOARD_W-1:0] SUL_BORDER_MASK = 32'hF808_0808;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAP  = 2'd1,
        LAND = 2'd2,
        DONE = 2'd3
    } scan_state_t;

    // Bits of s1 whose down-right neighbour is set in s2 (the captured pieces of this level).
    function automatic logic [BOARD_W-1:0] sdr_parents(input logic [BOARD_W-1:0] s1,
                                                       input logic [BOARD_W-1:0] s2);
        logic [BOARD_W-1:0] p;
        p = '0;
        for (int r = 0; r < ROWS - 1; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r[0] == 1'b0) begin
                    if (c < COLS - 1) begin
                        p[COLS*r+c] = s1[COLS*r+c] & s2[COLS*r+c+5];
                    end
                end else begin
                    p[COLS*r+c] = s1[COLS*r+c] & s2[COLS*r+c+4];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/sdr_jump_scan_sdr.sv
// Down-right board shift with unreachable border squares forced to 1 (mirror of the up-left shifter).
// Latency: purely combinational.
// Backpressure: none.
module sdr
    import board_pkg::*;
(
    input  logic [BOARD_W-1:0] a,
    output logic [BOARD_W-1:0] y
);

    // Even rows step to column+1 of the next row (column 3 falls off), odd rows keep their column.
    always_comb begin
        y = SDR_BORDER_MASK;
        for (int r = 0; r < ROWS - 1; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r[0] == 1'b0) begin
                    if (c < COLS - 1) begin
                        y[COLS*r+c+5] = a[COLS*r+c];
                    end
                end else begin
                    y[COLS*r+c+4] = a[COLS*r+c];
                end
            end
        end
    end

endmodule

// File: rtl/sdr_jump_scan.sv
// Iterative down-right jump-chain scanner; optional per-level trace under SDR_SCAN_TRACE_EN.
// Latency: 2N+1 / 2N+2 / 2*MAX_DEPTH edges from accepted start to DONE (N = successful levels).
// Backpressure: start only accepted in IDLE; requests while busy are dropped, not queued.
module sdr_jump_scan
    import board_pkg::*;
#(
    parameter int MAX_DEPTH = 3
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [BOARD_W-1:0] pieces,
    input  logic [BOARD_W-1:0] opp,
    input  logic [BOARD_W-1:0] empty,
    output logic               busy,
    output logic               done,
    output logic [BOARD_W-1:0] land,
    output logic [BOARD_W-1:0] cap,
    output logic [1:0]         depth
`ifdef SDR_SCAN_TRACE_EN
    ,
    output logic               trace_valid,
    output logic [BOARD_W-1:0] trace_land
`endif
);

    localparam logic [1:0] MAX_D = 2'(MAX_DEPTH);

    scan_state_t        state;
    scan_state_t        state_nxt;
    logic [BOARD_W-1:0] front;
    logic [BOARD_W-1:0] opp_r;
    logic [BOARD_W-1:0] empty_r;
    logic [BOARD_W-1:0] s1_r;
    logic [BOARD_W-1:0] sdr_cap_y;
    logic [BOARD_W-1:0] sdr_land_y;
    logic [BOARD_W-1:0] s1;
    logic [BOARD_W-1:0] s2;

    sdr u_sdr_cap  (.a(front), .y(sdr_cap_y));
    sdr u_sdr_land (.a(s1_r),  .y(sdr_land_y));

    // Border 1s from the shifter are stripped so they can never count as hits.
    assign s1 = sdr_cap_y  & opp_r   & ~SDR_BORDER_MASK;
    assign s2 = sdr_land_y & empty_r & ~SDR_BORDER_MASK;

    // Next-state decode: a failed CAP or LAND, or reaching the depth limit, ends the scan.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = CAP;
            CAP:  state_nxt = (s1 == '0) ? DONE : LAND;
            LAND: begin
                if (s2 == '0) begin
                    state_nxt = DONE;
                end else if (depth + 2'd1 == MAX_D) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = CAP;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state so outputs come straight off flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
        end
    end

    // Datapath: snapshot on accept, hold S1 between CAP and LAND, accumulate results per level.
    always_ff @(posedge clock) begin
        if (reset) begin
            front   <= '0;
            opp_r   <= '0;
            empty_r <= '0;
            s1_r    <= '0;
            land    <= '0;
            cap     <= '0;
            depth   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        front   <= pieces;
                        opp_r   <= opp;
                        empty_r <= empty;
                        s1_r    <= '0;
                        land    <= '0;
                        cap     <= '0;
                        depth   <= '0;
                    end
                end
                CAP: begin
                    if (s1 != '0) s1_r <= s1;
                end
                LAND: begin
                    if (s2 != '0) begin
                        land  <= land | s2;
                        cap   <= cap | sdr_parents(s1_r, s2);
                        depth <= depth + 2'd1;
                        front <= s2;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SDR_SCAN_TRACE_EN
    // One-cycle report of each level's landing squares after a successful LAND.
    always_ff @(posedge clock) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_land  <= '0;
        end else begin
            trace_valid <= (state == LAND) && (s2 != '0);
            if ((state == LAND) && (s2 != '0)) trace_land <= s2;
        end
    end
`endif

endmodule
